// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    SHIFT,
    STORE,
    HOLDOFF
  } state_t;

  localparam int HOLDOFF_CYCLES    = 2;
  localparam int DEFAULT_DATAWIDTH = 8;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Data-side port between the SPI shift engine (master) and the ring buffer (slave).
interface spi_shift_engine_if
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) ();

  logic [DATAWIDTH-1:0] txData;
  logic                 txValid;
  logic                 txRead;
  logic [DATAWIDTH-1:0] rxData;
  logic                 rxReady;
  logic                 rxWrite;

  modport master (
    input  txData, txValid, rxReady,
    output txRead, rxData, rxWrite
  );

  modport slave (
    output txData, txValid, rxReady,
    input  txRead, rxData, rxWrite
  );

endinterface

// File: rtl/spi_clock_divider.sv
// SCLK edge timer: emits a one-cycle tick every clkDivisor+1 cycles while running.
module spi_clock_divider #(
  parameter int DIVWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIVWIDTH-1:0] clkDivisor,
  input  logic                restart,
  input  logic                run,
  output logic                tick
);

  logic [DIVWIDTH-1:0] count;

  assign tick = run && !restart && (count == clkDivisor);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || !run || (count == clkDivisor)) begin
      count <= '0;
    end else begin
      count <= count + DIVWIDTH'(1);
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine between the ring buffer data port and the SPI pins.
// Define SPI_ENGINE_LSB_FIRST_EN to add the lsbFirst input (per-word LSB-first order).
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int DIVWIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIVWIDTH-1:0] clkDivisor,
  spi_shift_engine_if.master  ringBuf,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                csN,
  output logic                busy
`ifdef SPI_ENGINE_LSB_FIRST_EN
  ,
  input  logic                lsbFirst
`endif
);

  localparam int EW = $clog2(2 * DATAWIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATAWIDTH - 1);

  state_t               state;
  logic [EW-1:0]        edgeCnt;
  logic [1:0]           holdCnt;
  logic [DATAWIDTH-1:0] txShift;
  logic [DATAWIDTH-1:0] rxShift;
  logic                 cphaL;
  logic                 lsbL;
  logic                 lsbSel;
  logic [DIVWIDTH-1:0]  divL;
  logic                 tick;
  logic                 leading;
  logic                 sampleEdge;
  logic                 driveEdge;

`ifdef SPI_ENGINE_LSB_FIRST_EN
  assign lsbSel = lsbFirst;
`else
  assign lsbSel = 1'b0;
`endif

  function automatic logic headBit(input logic [DATAWIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATAWIDTH-1];
  endfunction

  function automatic logic [DATAWIDTH-1:0] shiftOut(input logic [DATAWIDTH-1:0] w,
                                                    input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATAWIDTH-1:0] shiftIn(input logic [DATAWIDTH-1:0] w,
                                                   input logic b, input logic lsb);
    return lsb ? {b, w[DATAWIDTH-1:1]} : {w[DATAWIDTH-2:0], b};
  endfunction

  spi_clock_divider #(.DIVWIDTH(DIVWIDTH)) uDivider (
    .clk       (clk),
    .reset     (reset),
    .clkDivisor(divL),
    .restart   (state == LOAD),
    .run       (state == SHIFT),
    .tick      (tick)
  );

  // edgeCnt counts edges already taken, so an even count means the next edge leads.
  // With cpha=1 the first bit is already on mosi from LOAD, so the first leading edge does not advance.
  assign leading    = ~edgeCnt[0];
  assign sampleEdge = tick && (leading != cphaL);
  assign driveEdge  = tick && (leading == cphaL) && (edgeCnt != '0) && (edgeCnt != LAST_EDGE);

  // Word datapath; contents are only meaningful from LOAD onward.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      txShift <= shiftOut(ringBuf.txData, lsbSel);
      cphaL   <= cpha;
      divL    <= clkDivisor;
      lsbL    <= lsbSel;
    end else if (state == SHIFT) begin
      if (driveEdge)  txShift <= shiftOut(txShift, lsbL);
      if (sampleEdge) rxShift <= shiftIn(rxShift, miso, lsbL);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ringBuf.txRead  <= 1'b0;
      ringBuf.rxWrite <= 1'b0;
      ringBuf.rxData  <= '0;
      sclk            <= 1'b0;
      mosi            <= 1'b0;
      csN             <= 1'b1;
      busy            <= 1'b0;
      edgeCnt         <= '0;
      holdCnt         <= '0;
    end else begin
      ringBuf.txRead  <= 1'b0;
      ringBuf.rxWrite <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (enable && ringBuf.txValid) begin
            state          <= FETCH;
            ringBuf.txRead <= 1'b1;
            busy           <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT:  state <= LOAD;
        LOAD: begin
          csN     <= 1'b0;
          sclk    <= cpol;
          mosi    <= headBit(ringBuf.txData, lsbSel);
          edgeCnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk    <= ~sclk;
            edgeCnt <= edgeCnt + EW'(1);
            if (driveEdge) mosi <= headBit(txShift, lsbL);
            if (edgeCnt == LAST_EDGE) state <= STORE;
          end
        end
        STORE: begin
          if (ringBuf.rxReady) begin
            ringBuf.rxWrite <= 1'b1;
            ringBuf.rxData  <= rxShift;
            holdCnt         <= '0;
            state           <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (holdCnt == 2'(HOLDOFF_CYCLES - 1)) begin
            if (enable && ringBuf.txValid) begin
              state          <= FETCH;
              ringBuf.txRead <= 1'b1;
            end else begin
              state <= IDLE;
              csN   <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            holdCnt <= holdCnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a registered ring-buffer model and miso looped to mosi.
module tb_spi_shift_engine;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic [DVW-1:0] clkDivisor = 16'd1;
  logic           sclk, mosi, miso, csN, busy;
`ifdef SPI_ENGINE_LSB_FIRST_EN
  logic           lsbFirst = 1'b0;
`endif

  spi_shift_engine_if #(.DATAWIDTH(DW)) ifc ();

  spi_shift_engine #(.DATAWIDTH(DW), .DIVWIDTH(DVW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cpol      (cpol),
    .cpha      (cpha),
    .clkDivisor(clkDivisor),
    .ringBuf   (ifc),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .csN       (csN),
    .busy      (busy)
`ifdef SPI_ENGINE_LSB_FIRST_EN
    ,
    .lsbFirst  (lsbFirst)
`endif
  );

  always #5 clk = ~clk;
  assign miso = mosi;

  // Ring buffer model: registered read data and valid flag.
  logic [7:0] txMem [0:7];
  logic [2:0] wrIdx = 3'd0;
  logic [2:0] rdIdx = 3'd0;

  always @(posedge clk) begin
    if (ifc.txRead) begin
      ifc.txData  <= txMem[rdIdx];
      rdIdx       <= rdIdx + 3'd1;
      ifc.txValid <= (rdIdx + 3'd1) != wrIdx;
    end else begin
      ifc.txValid <= rdIdx != wrIdx;
    end
  end

  // Pin and strobe monitor, sampled on the falling clock edge.
  int          cyc = 0, edges = 0, rises = 0, txReads = 0, rxWrites = 0, overlaps = 0;
  int          csLow = 0, csFalls = 0, csRises = 0, txReadCyc = 0, csFallCyc = 0;
  logic [15:0] mosiRise = 16'h0;
  logic [15:0] rxHist = 16'h0;
  logic        prevSclk = 1'b0;
  logic        prevCs = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sclk !== prevSclk) begin
      edges <= edges + 1;
      if (sclk) begin
        rises    <= rises + 1;
        mosiRise <= {mosiRise[14:0], mosi};
      end
    end
    prevSclk <= sclk;
    if (!csN) csLow <= csLow + 1;
    if (prevCs && !csN) begin
      csFalls   <= csFalls + 1;
      csFallCyc <= cyc;
    end
    if (!prevCs && csN) csRises <= csRises + 1;
    prevCs <= csN;
    if (ifc.txRead) begin
      txReads   <= txReads + 1;
      txReadCyc <= cyc;
    end
    if (ifc.rxWrite) begin
      rxWrites <= rxWrites + 1;
      rxHist   <= {rxHist[7:0], ifc.rxData};
    end
    if (ifc.txRead && ifc.rxWrite) overlaps <= overlaps + 1;
  end

  int checks = 0;
  int failures = 0;
  int bEdges, bRises, bTxReads, bRxWrites, bCsLow, bCsFalls, bCsRises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pushTx(input logic [7:0] d);
    txMem[wrIdx] = d;
    wrIdx = wrIdx + 3'd1;
  endtask

  task automatic baseline();
    bEdges    = edges;
    bRises    = rises;
    bTxReads  = txReads;
    bRxWrites = rxWrites;
    bCsLow    = csLow;
    bCsFalls  = csFalls;
    bCsRises  = csRises;
  endtask

  task automatic waitBusy(input logic level, input int limit, input string tag);
    int n = 0;
    while (busy !== level && n < limit) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, busy}, {31'd0, level});
  endtask

  task automatic waitEdges(input int count, input int limit, input string tag);
    int n = 0;
    while ((edges - bEdges) < count && n < limit) begin
      step(1);
      n++;
    end
    check(tag, edges - bEdges, count);
  endtask

  task automatic waitWord(input string tag);
    waitBusy(1'b1, 40, {tag, "_start"});
    waitBusy(1'b0, 800, {tag, "_done"});
    step(2);
  endtask

  initial begin
    ifc.rxReady = 1'b1;

    // Reset state
    step(3);
    check("rst_txRead", {31'd0, ifc.txRead}, 0);
    check("rst_rxWrite", {31'd0, ifc.rxWrite}, 0);
    check("rst_rxData", {24'd0, ifc.rxData}, 0);
    check("rst_sclk", {31'd0, sclk}, 0);
    check("rst_mosi", {31'd0, mosi}, 0);
    check("rst_csN", {31'd0, csN}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    step(2);
    check("idle_sclk_mode0", {31'd0, sclk}, 0);

    // Mode 0, divisor 1, single word 0xA5
    enable = 1'b1;
    baseline();
    pushTx(8'hA5);
    waitWord("m0");
    check("m0_rxData", {24'd0, rxHist[7:0]}, 32'hA5);
    check("m0_mosiBits", {24'd0, mosiRise[7:0]}, 32'hA5);
    check("m0_rises", rises - bRises, 8);
    check("m0_edges", edges - bEdges, 16);
    check("m0_txReads", txReads - bTxReads, 1);
    check("m0_rxWrites", rxWrites - bRxWrites, 1);
    check("m0_csLowCycles", csLow - bCsLow, 35);
    check("m0_readToCs", csFallCyc - txReadCyc, 3);
    check("m0_csN_end", {31'd0, csN}, 1);
    check("m0_sclk_end", {31'd0, sclk}, 0);

    // Mode 3, divisor 0, back-to-back 0x3C then 0xC3
    cpol = 1'b1;
    cpha = 1'b1;
    clkDivisor = 16'd0;
    step(2);
    check("idle_sclk_mode3", {31'd0, sclk}, 1);
    baseline();
    pushTx(8'h3C);
    pushTx(8'hC3);
    waitWord("m3");
    check("m3_rxData", {16'd0, rxHist}, 32'h3CC3);
    check("m3_mosiBits", {16'd0, mosiRise}, 32'h3CC3);
    check("m3_txReads", txReads - bTxReads, 2);
    check("m3_rxWrites", rxWrites - bRxWrites, 2);
    check("m3_edges", edges - bEdges, 32);
    check("m3_csFalls", csFalls - bCsFalls, 1);
    check("m3_csRises", csRises - bCsRises, 1);
    check("m3_csLowCycles", csLow - bCsLow, 41);
    check("m3_sclk_end", {31'd0, sclk}, 1);

    // Receive side full: STORE stalls for 20 cycles
    cpol = 1'b0;
    cpha = 1'b0;
    ifc.rxReady = 1'b0;
    step(2);
    check("idle_sclk_back0", {31'd0, sclk}, 0);
    baseline();
    pushTx(8'h5A);
    waitEdges(16, 100, "stall_edges_wait");
    step(20);
    check("stall_noWrite", rxWrites - bRxWrites, 0);
    check("stall_busy", {31'd0, busy}, 1);
    check("stall_csN", {31'd0, csN}, 0);
    check("stall_sclk", {31'd0, sclk}, 0);
    check("stall_edges", edges - bEdges, 16);
    ifc.rxReady = 1'b1;
    waitBusy(1'b0, 50, "stall_release");
    step(2);
    check("stall_rxWrites", rxWrites - bRxWrites, 1);
    check("stall_rxData", {24'd0, rxHist[7:0]}, 32'h5A);
    check("stall_edges_after", edges - bEdges, 16);
    check("stall_mosiBits", {24'd0, mosiRise[7:0]}, 32'h5A);

    // enable dropped at the 5th edge with a second word queued
    clkDivisor = 16'd1;
    step(1);
    baseline();
    pushTx(8'h96);
    pushTx(8'h11);
    waitEdges(5, 100, "en_edge5_wait");
    enable = 1'b0;
    waitBusy(1'b0, 200, "en_done");
    step(10);
    check("en_txReads", txReads - bTxReads, 1);
    check("en_rxWrites", rxWrites - bRxWrites, 1);
    check("en_rxData", {24'd0, rxHist[7:0]}, 32'h96);
    check("en_csN", {31'd0, csN}, 1);
    check("en_busy", {31'd0, busy}, 0);

    // Reset in SHIFT, then a clean restart
    baseline();
    enable = 1'b1;
    waitBusy(1'b1, 40, "rs_start");
    waitEdges(3, 100, "rs_edge3_wait");
    check("rs_pre_csN", {31'd0, csN}, 0);
    check("rs_pre_sclk", {31'd0, sclk}, 1);
    reset = 1'b1;
    #1;
    check("rs_csN", {31'd0, csN}, 1);
    check("rs_sclk", {31'd0, sclk}, 0);
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_mosi", {31'd0, mosi}, 0);
    step(2);
    pushTx(8'h42);
    step(1);
    baseline();
    reset = 1'b0;
    waitWord("rs_next");
    check("rs_txReads", txReads - bTxReads, 1);
    check("rs_rxWrites", rxWrites - bRxWrites, 1);
    check("rs_rxData", {24'd0, rxHist[7:0]}, 32'h42);
    check("rs_edges", edges - bEdges, 16);
    check("rs_mosiBits", {24'd0, mosiRise[7:0]}, 32'h42);
    check("rs_readToCs", csFallCyc - txReadCyc, 3);
    check("rs_overlaps", overlaps, 0);

`ifdef SPI_ENGINE_LSB_FIRST_EN
    // LSB-first word 0x01
    lsbFirst = 1'b1;
    baseline();
    pushTx(8'h01);
    waitWord("lsb");
    check("lsb_rxData", {24'd0, rxHist[7:0]}, 32'h01);
    check("lsb_mosiBits", {24'd0, mosiRise[7:0]}, 32'h80);
    check("lsb_rxWrites", rxWrites - bRxWrites, 1);
    lsbFirst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
